// File: rtl/md_pad_serializer.sv
// Responder-side model of the two-pad Megadrive shifter board: synchronises the host strobes and serialises a 16-bit pad frame.
// Optional feature macro: MD_SIX_BUTTON_EN (6-button phase counter, TH timeout and cnt=3/4 pin mappings).
module md_pad_serializer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TH_TIMEOUT  = 16384
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        joy_clk,
    input  logic        joy_load_n,
    input  logic        sel,
    input  logic [11:0] joy1_i,
    input  logic [11:0] joy2_i,
    output logic        joy_data,
    output logic [2:0]  pad_phase_o
);

    localparam int unsigned FRAME_W = 16;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TH_TIMEOUT < 2) begin : g_param_check
        $error("md_pad_serializer: SYNC_STAGES must be 2..4 and TH_TIMEOUT >= 2");
    end

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic [SYNC_STAGES-1:0] sel_sync;
    logic                   clk_d;
    logic                   clk_s;
    logic                   load_s;
    logic                   sel_s;
    logic                   clk_rise;
    logic [2:0]             cnt;
    logic [FRAME_W-1:0]     shifter;
    logic [FRAME_W-1:0]     frame_word;

    // Strobe synchronisers plus one delayed copy of the shift clock for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '0;
            load_sync <= '1;
            sel_sync  <= '1;
            clk_d     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
            load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load_n};
            sel_sync  <= {sel_sync[SYNC_STAGES-2:0], sel};
            clk_d     <= clk_s;
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign load_s   = load_sync[SYNC_STAGES-1];
    assign sel_s    = sel_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_d;

`ifdef MD_SIX_BUTTON_EN
    localparam int unsigned TMR_W = $clog2(TH_TIMEOUT + 1);

    logic             sel_d;
    logic             sel_fall;
    logic [TMR_W-1:0] timer;

    assign sel_fall = sel_d & ~sel_s;

    // TH phase counter: advances on TH falling edges, cleared after a quiet period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_d <= 1'b1;
            timer <= '0;
            cnt   <= 3'd0;
        end else begin
            sel_d <= sel_s;
            if (sel_fall) begin
                timer <= '0;
                cnt   <= (cnt == 3'd4) ? 3'd4 : cnt + 3'd1;
            end else if (timer != TMR_W'(TH_TIMEOUT)) begin
                timer <= timer + TMR_W'(1);
                if (timer == TMR_W'(TH_TIMEOUT - 1)) begin
                    cnt <= 3'd0;
                end
            end
        end
    end

    function automatic logic [5:0] pad_vec(input logic [11:0] b, input logic s, input logic [2:0] c);
        logic [5:0] v;
        if (s) begin
            v = (c == 3'd3) ? {2'b11, b[11:8]} : {b[5:4], b[3:0]};
        end else begin
            case (c)
                3'd3:    v = {b[7:6], 4'b0000};
                3'd4:    v = {b[7:6], 4'b1111};
                default: v = {b[7:6], 2'b00, b[1:0]};
            endcase
        end
        return v;
    endfunction

    assign frame_word = {2'b11, pad_vec(joy1_i, sel_s, cnt), 2'b11, pad_vec(joy2_i, sel_s, cnt)};
`else
    logic unused_mxyz;

    assign cnt        = 3'd1;
    assign unused_mxyz = ^{joy1_i[11:8], joy2_i[11:8]};

    function automatic logic [5:0] pad_vec(input logic [7:0] b, input logic s);
        return s ? {b[5:4], b[3:0]} : {b[7:6], 2'b00, b[1:0]};
    endfunction

    assign frame_word = {2'b11, pad_vec(joy1_i[7:0], sel_s), 2'b11, pad_vec(joy2_i[7:0], sel_s)};
`endif

    assign pad_phase_o = cnt;

    // Parallel-in/serial-out shifter: load has priority over a shift edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shifter <= '1;
        end else if (!load_s) begin
            shifter <= frame_word;
        end else if (clk_rise) begin
            shifter <= {shifter[FRAME_W-2:0], 1'b1};
        end
    end

    assign joy_data = shifter[FRAME_W-1];

endmodule

// File: tb/tb_md_pad_serializer.sv
// Scoreboard bench for md_pad_serializer: frame bits and phase values are queued by the stimulus and checked by monitors.
module tb_md_pad_serializer;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TH   = 500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        joy_clk = 1'b0;
    logic        joy_load_n = 1'b1;
    logic        sel = 1'b1;
    logic [11:0] joy1_i = 12'hFFF;
    logic [11:0] joy2_i = 12'hFFF;
    logic        joy_data;
    logic [2:0]  pad_phase_o;

    int checks = 0;
    int failures = 0;

    logic       bit_q[$];
    string      bit_name_q[$];
    logic [2:0] phase_q[$];
    string      phase_name_q[$];
    event       phase_ev;

`ifdef MD_SIX_BUTTON_EN
    localparam bit SIX = 1'b1;
`else
    localparam bit SIX = 1'b0;
`endif

    md_pad_serializer #(.SYNC_STAGES(SYNC), .TH_TIMEOUT(TH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .joy_clk     (joy_clk),
        .joy_load_n  (joy_load_n),
        .sel         (sel),
        .joy1_i      (joy1_i),
        .joy2_i      (joy2_i),
        .joy_data    (joy_data),
        .pad_phase_o (pad_phase_o)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_phase(input string name, input logic [2:0] v);
        phase_q.push_back(v);
        phase_name_q.push_back(name);
        ->phase_ev;
    endtask

    // Host samples the data pin just before each shift edge
    always @(posedge joy_clk) begin
        logic  e;
        string n;
        checks++;
        if (bit_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_shift: got %b expected no shift", joy_data);
        end else begin
            e = bit_q.pop_front();
            n = bit_name_q.pop_front();
            if (joy_data !== e) begin
                failures++;
                $display("FAIL %s: got %b expected %b", n, joy_data, e);
            end
        end
    end

    initial begin
        logic [2:0] e;
        string      n;
        forever begin
            @(phase_ev);
            while (phase_q.size() > 0) begin
                e = phase_q.pop_front();
                n = phase_name_q.pop_front();
                checks++;
                if (pad_phase_o !== e) begin
                    failures++;
                    $display("FAIL %s: got %0d expected %0d", n, pad_phase_o, e);
                end
            end
        end
    end

    // Load a frame and clock out nbits; buttons are inverted while shifting to prove they are not resampled
    task automatic run_frame(input string name, input logic [15:0] exp, input int nbits);
        logic [11:0] j1;
        logic [11:0] j2;
        for (int k = 0; k < nbits; k++) begin
            bit_q.push_back(exp[15-k]);
            bit_name_q.push_back($sformatf("%s_bit%0d", name, k));
        end
        joy_load_n = 1'b0;
        cyc(6);
        joy_load_n = 1'b1;
        cyc(6);
        j1 = joy1_i;
        j2 = joy2_i;
        joy1_i = ~j1;
        joy2_i = ~j2;
        for (int k = 0; k < nbits; k++) begin
            joy_clk = 1'b1;
            cyc(4);
            joy_clk = 1'b0;
            cyc(4);
        end
        joy1_i = j1;
        joy2_i = j2;
    endtask

    initial begin
        cyc(3);
        chk("reset_data", int'(joy_data), 1);
        exp_phase("reset_phase", SIX ? 3'd0 : 3'd1);
        reset_n = 1'b1;
        cyc(2);

        run_frame("idle", 16'hFFFF, 16);
        exp_phase("idle_phase", SIX ? 3'd0 : 3'd1);

        joy1_i = 12'hFFE;
        run_frame("up1", 16'hFEFF, 16);

        // Three TH falling edges, ending low, with pad2 A pressed
        joy1_i = 12'hFFF;
        joy2_i = 12'hFBF;
        for (int i = 0; i < 3; i++) begin
            sel = 1'b0;
            cyc(6);
            if (i < 2) begin
                sel = 1'b1;
                cyc(6);
            end
        end
        exp_phase("phase3", SIX ? 3'd3 : 3'd1);
        run_frame("th_low3", SIX ? 16'hF0E0 : 16'hF3E3, 16);

        sel = 1'b1;
        joy1_i = 12'h7FF;
        cyc(4);
        exp_phase("phase3_high", SIX ? 3'd3 : 3'd1);
        run_frame("th_high3", SIX ? 16'hF7FF : 16'hFFFF, 16);

        // Fourth falling edge: latency of the phase update
        joy1_i = 12'hF7F;
        sel = 1'b0;
        cyc(SYNC);
        exp_phase("phase_before_edge", SIX ? 3'd3 : 3'd1);
        cyc(1);
        exp_phase("phase_after_edge", SIX ? 3'd4 : 3'd1);
        cyc(4);
        run_frame("th_low4", SIX ? 16'hDFEF : 16'hD3E3, 16);

        // Saturation, then timeout measured from the last falling edge
        sel = 1'b1;
        cyc(6);
        sel = 1'b0;
        cyc(SYNC + 1);
        exp_phase("phase_saturate", SIX ? 3'd4 : 3'd1);
        cyc(TH - 1);
        exp_phase("phase_pre_timeout", SIX ? 3'd4 : 3'd1);
        cyc(1);
        exp_phase("phase_timeout", SIX ? 3'd0 : 3'd1);

        run_frame("low_after_timeout", 16'hD3E3, 16);

        sel = 1'b1;
        joy1_i = 12'hFDF;
        joy2_i = 12'hFEF;
        cyc(4);
        run_frame("cb", 16'hDFEF, 16);

        // Reset in the middle of a frame, then a clean reload
        joy1_i = 12'hFFB;
        joy2_i = 12'hFFF;
        run_frame("abort", 16'hFBFF, 5);
        chk("pre_reset_data", int'(joy_data), 0);
        reset_n = 1'b0;
        #1;
        chk("async_reset_data", int'(joy_data), 1);
        cyc(3);
        chk("held_reset_data", int'(joy_data), 1);
        exp_phase("abort_reset_phase", SIX ? 3'd0 : 3'd1);
        reset_n = 1'b1;
        cyc(2);
        run_frame("reload", 16'hFBFF, 16);

        cyc(4);
        chk("bits_pending", bit_q.size(), 0);
        chk("phases_pending", phase_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_pad_serializer.md
# md_pad_serializer

Responder-side model of the two-pad Megadrive joystick interface. It emulates the external parallel-in/serial-out shifter board and two 6-button Megadrive pads that share one select (TH) line. It takes the host's `joy_clk`, `joy_load_n` and select strobes and drives `joy_data` with a 16-bit frame. Used as a board-less joystick source (USB/keyboard mapping) and as the bench counterpart of the joystick decoder.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on `joy_clk`, `joy_load_n` and `sel`; legal range 2..4.
- `TH_TIMEOUT`, default 16384: clk cycles without a `sel` falling edge before a pad's 6-button phase counter returns to 0; must be ≥ 2.

Ports:
- `clk` in 1: single system clock; must be ≥ 4× the `joy_clk` rate.
- `reset_n` in 1: asynchronous, active-low reset.
- `joy_clk` in 1: host shift clock; a bit is shifted on each synchronised rising edge.
- `joy_load_n` in 1: host parallel load; while low, the shifter captures continuously.
- `sel` in 1: TH select level shared by both pads; 1 = TH high.
- `joy1_i` in 12: pad 1 buttons, MXYZ SACB RLDU, negative logic (0 = pressed).
- `joy2_i` in 12: pad 2 buttons, same format.
- `joy_data` out 1: serial data, MSB first.
- `pad_phase_o` out 3: shared phase counter value (0..4), for verification.

## Operation
- All three strobes pass through `SYNC_STAGES` flops. Edge detection uses the last synchroniser stage against one extra delayed copy.
- Phase counter `cnt` (3 bit):
  - Increments on each synchronised `sel` falling edge; saturates at 4.
  - Timer clears on each `sel` falling edge. When `TH_TIMEOUT` cycles elapse without a falling edge, `cnt` is set to 0 on that cycle and the timer saturates.
- Pad pin vector `{p9,p6,R,L,D,U}` from button inputs (b = bit of `joyN_i`), by `sel` level and `cnt`:
  - `sel`=1, cnt∈{0,1,2,4}: {C,B,R,L,D,U}.
  - `sel`=0, cnt∈{1,2}: {S,A,0,0,D,U}.
  - `sel`=0, cnt=3: {S,A,0,0,0,0}.
  - `sel`=1, cnt=3: {1,1,M,X,Y,Z}, with U=Z, D=Y, L=X, R=M.
  - `sel`=0, cnt=4: {S,A,1,1,1,1}.
  - `sel`=0, cnt=0 (only possible after timeout while low): treated as cnt=1.
- Frame word W[15:0] = {1,1,pad1 vector, 1,1,pad2 vector}.
- Shifter (16 bit):
  - While synchronised load is low, it loads W every clk.
  - On a `joy_clk` rising edge with load high, it shifts left and fills with 1.
  - `joy_data` is shifter[15].
  - After 16 shifts without a load, `joy_data` stays 1.
- Simultaneous load low and `joy_clk` edge: load wins; no shift occurs.
- A `sel` change during load is reflected in the captured W one cycle after the synchronised `sel` changes.

## Timing
- Reset values:
  - shifter all 1s, so `joy_data`=1.
  - `cnt`=0 and `pad_phase_o`=0.
  - timeout timer 0.
  - synchroniser flops: 1 for `joy_load_n`, 0 for `joy_clk`, 1 for `sel`.
- Strobe-to-`joy_data` latency: `SYNC_STAGES`+1 clk after the pin edge.
- `sel` edge to `cnt` update: `SYNC_STAGES`+1 clk.
- Asserting `reset_n` mid-frame aborts the frame immediately; `joy_data` returns to 1 asynchronously.
- Buttons are sampled only during load; changes between loads are not visible until the next load.

## Configuration
- `MD_SIX_BUTTON_EN` defined: phase counter, timeout and cnt=3/4 mappings present, as above.
- `MD_SIX_BUTTON_EN` undefined:
  - `cnt` is held at 1 and `pad_phase_o`=1.
  - The pad behaves as a 3-button pad: `sel`=1 gives {C,B,R,L,D,U}; `sel`=0 gives {S,A,0,0,D,U}.
  - The timeout logic is removed.

## Test plan
- Reset, then `joy1_i`=`joy2_i`=12'hFFF, `sel`=1, one load followed by 16 clocks → `joy_data` sequence is 16 ones; `pad_phase_o`=0.
- `joy1_i`=12'hFFE (U pressed), `sel`=1, load + 16 clocks → bit 7 (counting from 0, first bit out) is 0; all others are 1.
- Three `sel` falling edges within `TH_TIMEOUT`, `sel`=0, `joy2_i` A pressed → pad2 vector reads {1,0,0,0,0,0}, `pad_phase_o`=3.
- Continue to `sel`=1 with cnt=3 and pad1 M pressed → pad1 R position (frame bit 4) is 0, p9/p6 read 1.
- One `sel` falling edge then `TH_TIMEOUT` idle cycles → `pad_phase_o` returns to 0 on exactly cycle `TH_TIMEOUT`.
- `reset_n` asserted after 5 shifts, released, then a new load → `joy_data`=1 during reset and the full 16-bit frame is correct after the load.
